// File: rtl/exhaustive_vector_sequencer.sv
// Sweeps a DUT through every input vector 0..2^N_IN-1, samples its single output bit after a
// programmable settle time and streams (vector, result) pairs out over valid/ready.
module exhaustive_vector_sequencer #(
   parameter int unsigned N_IN   = 8,
   parameter int unsigned SETTLE = 1
) (
   input  logic            CK,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   output logic [0:N_IN-1] vec_out,
   input  logic            dut_out,
   output logic            sample_valid,
   input  logic            sample_ready,
   output logic [0:N_IN-1] sample_vec,
   output logic            sample_bit,
   output logic            busy,
   output logic            done,
   output logic [N_IN:0]   ones_count
);

   typedef enum logic [2:0] {StIdle, StApply, StSample, StEmit, StDone} state_e;

   localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

   state_e            state_q, state_d;
   logic [N_IN-1:0]   cnt_q, cnt_d;
   logic [7:0]        settle_q, settle_d;
   logic [N_IN-1:0]   svec_q, svec_d;
   logic              sbit_q, sbit_d;
   logic [N_IN:0]     ones_q, ones_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      svec_d   = svec_q;
      sbit_d   = sbit_q;
      ones_d   = ones_q;

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               state_d  = StApply;
               cnt_d    = '0;
               settle_d = '0;
               ones_d   = '0;
            end
         end
         StApply: begin
            if (settle_q == SettleLast) begin
               state_d = StSample;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         StSample: begin
            svec_d  = cnt_q;
            sbit_d  = dut_out;
            if (dut_out) begin
               ones_d = ones_q + (N_IN + 1)'(1);
            end
            state_d = StEmit;
         end
         StEmit: begin
            if (sample_ready) begin
               // Terminal check happens before the increment so the counter never wraps.
               if (&cnt_q) begin
                  state_d = StDone;
               end else begin
                  cnt_d    = cnt_q + N_IN'(1);
                  settle_d = '0;
                  state_d  = StApply;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Abort discards any in-flight capture/transfer but keeps the partial signature.
      if (abort && (state_q != StIdle)) begin
         state_d  = StIdle;
         cnt_d    = cnt_q;
         settle_d = '0;
         svec_d   = svec_q;
         sbit_d   = sbit_q;
         ones_d   = ones_q;
      end
   end

   always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         settle_q <= '0;
         svec_q   <= '0;
         sbit_q   <= 1'b0;
         ones_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         svec_q   <= svec_d;
         sbit_q   <= sbit_d;
         ones_q   <= ones_d;
      end
   end

   always_comb begin
      busy         = (state_q == StApply) || (state_q == StSample) || (state_q == StEmit);
      vec_out      = busy ? cnt_q : '0;
      sample_valid = (state_q == StEmit);
      done         = (state_q == StDone);
      sample_vec   = svec_q;
      sample_bit   = sbit_q;
      ones_count   = ones_q;
   end

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Self-checking bench: table of full sweeps plus abort, async reset and SETTLE=4 sequences,
// with a queue scoreboard of expected (vector, bit) pairs.
module tb_exhaustive_vector_sequencer;

   typedef struct packed {
      logic [7:0] v;
      logic       b;
   } exp_t;

   typedef struct {
      int mode;
      int stall_vec;
      int stall_len;
      int exp_ones;
      int exp_cyc;
   } sweep_t;

   logic       CK;
   logic       reset;
   logic       start;
   logic       abort;
   logic [0:7] vec_out;
   logic       dut_out;
   logic       sample_valid;
   logic       sample_ready;
   logic [0:7] sample_vec;
   logic       sample_bit;
   logic       busy;
   logic       done;
   logic [8:0] ones_count;

   logic       start4;
   logic [0:7] vec_out4;
   logic       dut_out4;
   logic       valid4;
   logic [0:7] svec4;
   logic       sbit4;
   logic       busy4;
   logic       done4;
   logic [8:0] ones4;

   int   mode;
   int   stall_vec;
   int   stall_left;
   exp_t q[$];
   int   checks;
   int   failures;

   exhaustive_vector_sequencer #(.N_IN(8), .SETTLE(1)) u_dut (
      .CK          (CK),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .vec_out     (vec_out),
      .dut_out     (dut_out),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .sample_vec  (sample_vec),
      .sample_bit  (sample_bit),
      .busy        (busy),
      .done        (done),
      .ones_count  (ones_count)
   );

   exhaustive_vector_sequencer #(.N_IN(8), .SETTLE(4)) u_dut4 (
      .CK          (CK),
      .reset       (reset),
      .start       (start4),
      .abort       (1'b0),
      .vec_out     (vec_out4),
      .dut_out     (dut_out4),
      .sample_valid(valid4),
      .sample_ready(1'b1),
      .sample_vec  (svec4),
      .sample_bit  (sbit4),
      .busy        (busy4),
      .done        (done4),
      .ones_count  (ones4)
   );

   function automatic logic model(input int m, input logic [7:0] v);
      case (m)
         0:       return &v;
         1:       return ~v[0];
         default: return ^v;
      endcase
   endfunction

   always_comb dut_out  = model(mode, vec_out);
   always_comb dut_out4 = &vec_out4;

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic fill_queue();
      q.delete();
      for (int v = 0; v < 256; v++) begin
         q.push_back('{v: 8'(v), b: model(mode, 8'(v))});
      end
   endtask

   // One cycle: choose ready for the coming edge, retire a transfer, move to the next negedge.
   task automatic tick();
      exp_t e;
      if (sample_valid && stall_left > 0 && int'(sample_vec) == stall_vec) begin
         sample_ready = 1'b0;
         stall_left--;
         check("stall_vec", 32'(sample_vec), 32'(stall_vec));
         check("stall_bit", 32'(sample_bit), 32'(model(mode, 8'(stall_vec))));
         check("stall_vec_out", 32'(vec_out), 32'(stall_vec));
      end else begin
         sample_ready = 1'b1;
      end
      if (sample_valid && sample_ready) begin
         if (q.size() == 0) begin
            check("sb_underflow", 32'(q.size()), 32'd1);
         end else begin
            e = q.pop_front();
            check("xfer_vec", 32'(sample_vec), 32'(e.v));
            check("xfer_bit", 32'(sample_bit), 32'(e.b));
         end
      end
      @(negedge CK);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_vec_out"}, 32'(vec_out), 32'd0);
      check({tag, "_valid"}, 32'(sample_valid), 32'd0);
      check({tag, "_svec"}, 32'(sample_vec), 32'd0);
      check({tag, "_sbit"}, 32'(sample_bit), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_ones"}, 32'(ones_count), 32'd0);
   endtask

   task automatic run_sweep(input sweep_t s);
      int cyc;
      mode       = s.mode;
      stall_vec  = s.stall_vec;
      stall_left = s.stall_len;
      fill_queue();
      sample_ready = 1'b1;
      start        = 1'b1;
      @(negedge CK);
      start = 1'b0;
      cyc   = 1;
      check("start_busy", 32'(busy), 32'd1);
      check("start_vec0", 32'(vec_out), 32'd0);
      check("start_ones_clr", 32'(ones_count), 32'd0);
      while (done !== 1'b1 && cyc < 2000) begin
         start = (cyc == 100);  // must be ignored mid-sweep
         tick();
         cyc++;
      end
      start = 1'b0;
      check("done_seen", 32'(done), 32'd1);
      check("sweep_cycles", 32'(cyc), 32'(s.exp_cyc));
      check("sweep_ones", 32'(ones_count), 32'(s.exp_ones));
      check("sb_empty", 32'(q.size()), 32'd0);
      check("done_busy", 32'(busy), 32'd0);
      start = 1'b1;  // during DONE, must be ignored
      @(negedge CK);
      start = 1'b0;
      check("done_pulse_one", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("ones_hold", 32'(ones_count), 32'(s.exp_ones));
      @(negedge CK);
      check("start_in_done_ign", 32'(busy), 32'd0);
   endtask

   sweep_t tbl[3];

   initial begin
      int n;
      int exp_part;
      int xfers;
      int cyc;

      tbl[0] = '{mode: 0, stall_vec: -1, stall_len: 0, exp_ones: 1,   exp_cyc: 769};
      tbl[1] = '{mode: 1, stall_vec: 3,  stall_len: 5, exp_ones: 128, exp_cyc: 774};
      tbl[2] = '{mode: 2, stall_vec: -1, stall_len: 0, exp_ones: 128, exp_cyc: 769};

      checks = 0; failures = 0;
      mode = 0; stall_vec = -1; stall_left = 0;
      start = 1'b0; abort = 1'b0; sample_ready = 1'b1; start4 = 1'b0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #1 check_reset_vals("rst");
      @(negedge CK);
      @(negedge CK);
      reset = 1'b1;

      // abort beats start in IDLE
      start = 1'b1; abort = 1'b1;
      @(negedge CK);
      start = 1'b0; abort = 1'b0;
      check("abort_start_busy", 32'(busy), 32'd0);
      check("abort_start_vec", 32'(vec_out), 32'd0);

      for (int i = 0; i < 3; i++) run_sweep(tbl[i]);

      // Abort during EMIT of vector 10
      mode = 1; stall_vec = -1; stall_left = 0;
      fill_queue();
      start = 1'b1;
      @(negedge CK);
      start = 1'b0;
      n = 0;
      while (!(sample_valid && sample_vec == 8'd10) && n < 200) begin
         tick();
         n++;
      end
      check("abort_reach_v10", 32'(sample_valid && sample_vec == 8'd10), 32'd1);
      exp_part = 0;
      for (int v = 0; v <= 10; v++) exp_part += int'(model(1, 8'(v)));
      abort = 1'b1; sample_ready = 1'b1;
      @(negedge CK);
      abort = 1'b0;
      check("abort_valid", 32'(sample_valid), 32'd0);
      check("abort_vec_out", 32'(vec_out), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_ones", 32'(ones_count), 32'(exp_part));
      check("abort_xfers", 32'(q.size()), 32'd246);
      @(negedge CK);
      check("abort_no_done", 32'(done), 32'd0);
      run_sweep(tbl[0]);

      // Asynchronous reset during APPLY of vector 50
      mode = 2; stall_vec = -1; stall_left = 0;
      fill_queue();
      start = 1'b1;
      @(negedge CK);
      start = 1'b0;
      n = 0;
      while (!(busy && !sample_valid && vec_out == 8'd50) && n < 400) begin
         tick();
         n++;
      end
      check("reset_reach_v50", 32'(vec_out), 32'd50);
      #1 reset = 1'b0;
      #1 check_reset_vals("async_rst");
      @(negedge CK);
      reset = 1'b1;
      run_sweep(tbl[2]);

      // SETTLE=4 instance: 256*6 cycles, done in cycle 1537
      start4 = 1'b1;
      @(negedge CK);
      start4 = 1'b0;
      cyc   = 1;
      xfers = 0;
      check("s4_busy", 32'(busy4), 32'd1);
      while (done4 !== 1'b1 && cyc < 3000) begin
         if (valid4) begin
            xfers++;
            if (svec4 == 8'd255 || svec4 == 8'd254) begin
               check("s4_bit", 32'(sbit4), 32'(svec4 == 8'd255));
            end
         end
         @(negedge CK);
         cyc++;
      end
      check("s4_done", 32'(done4), 32'd1);
      check("s4_cycles", 32'(cyc), 32'd1537);
      check("s4_xfers", 32'(xfers), 32'd256);
      check("s4_ones", 32'(ones4), 32'd1);
      @(negedge CK);
      check("s4_done_pulse", 32'(done4), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
